// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings for the execute sequencer.
//   - FSM state encoding (also exported on the STATE debug port)
//   - 5-bit opcode values taken from INSTR[15:11]
//   - operation-class codes produced by alu_op_classify
//   - list of opcodes that update the carry flag in writeback
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MULW  = 3'd2,
    ST_MEMW  = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  localparam logic [4:0] OP_ADR  = 5'b00001;
  localparam logic [4:0] OP_ADM0 = 5'b00010;
  localparam logic [4:0] OP_ADM1 = 5'b00011;
  localparam logic [4:0] OP_ADI  = 5'b00100;
  localparam logic [4:0] OP_SBR  = 5'b00101;
  localparam logic [4:0] OP_SBM0 = 5'b00110;
  localparam logic [4:0] OP_SBM1 = 5'b00111;
  localparam logic [4:0] OP_SBI  = 5'b01000;
  localparam logic [4:0] OP_MLR  = 5'b01001;
  localparam logic [4:0] OP_XSL  = 5'b01010;
  localparam logic [4:0] OP_XSR  = 5'b01011;
  localparam logic [4:0] OP_BBO  = 5'b01100;
  localparam logic [4:0] OP_STK  = 5'b01101;
  localparam logic [4:0] OP_LDR  = 5'b01110;
  localparam logic [4:0] OP_STI  = 5'b01111;
  localparam logic [4:0] OP_JMR  = 5'b11100;

  localparam logic [2:0] CLS_NOP = 3'd0;
  localparam logic [2:0] CLS_ALU = 3'd1;
  localparam logic [2:0] CLS_MUL = 3'd2;
  localparam logic [2:0] CLS_MEM = 3'd3;
  localparam logic [2:0] CLS_JMP = 3'd4;

  // Opcodes whose writeback replaces CARRY with the ALU carry-out.
  // bbo, stk and ldr are deliberately absent: they preserve the flag.
  localparam int N_CARRY_WR = 11;
  localparam logic [4:0] CARRY_WR_OPS [N_CARRY_WR] = '{
    OP_ADR, OP_ADM0, OP_ADM1, OP_ADI, OP_SBR, OP_SBM0,
    OP_SBM1, OP_SBI, OP_MLR, OP_XSL, OP_XSR
  };

  function automatic logic is_carry_writer(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CARRY_WR; i++) begin
      if (op == CARRY_WR_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_op_classify.sv
// alu_op_classify: combinational opcode decode for the execute sequencer.
// Ports:
//   op_i        opcode, INSTR[15:11]
//   bit6_i      INSTR[6], selects push (1) vs pop (0) for stk
//   cls_o       operation class (CLS_* from alu_seq_pkg)
//   mem_we_o    memory access is a write (sti, or stk push)
//   carry_wr_o  writeback updates the carry flag
module alu_op_classify
  import alu_seq_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic       bit6_i,
  output logic [2:0] cls_o,
  output logic       mem_we_o,
  output logic       carry_wr_o
);

  always_comb begin
    cls_o      = CLS_NOP;
    mem_we_o   = 1'b0;
    carry_wr_o = is_carry_writer(op_i);
    case (op_i)
      OP_ADR, OP_ADM0, OP_ADM1, OP_ADI, OP_SBR, OP_SBM0,
      OP_SBM1, OP_SBI, OP_XSL, OP_XSR, OP_BBO: cls_o = CLS_ALU;
      OP_MLR: cls_o = CLS_MUL;
      OP_STK: begin
        cls_o    = CLS_MEM;
        mem_we_o = bit6_i;
      end
      OP_LDR: cls_o = CLS_MEM;
      OP_STI: begin
        cls_o    = CLS_MEM;
        mem_we_o = 1'b1;
      end
      OP_JMR: cls_o = CLS_JMP;
      default: cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: multi-cycle execute controller for the 16-bit core.
// Accepts instructions over a valid/ready handshake, holds them in the
// instruction register, sequences execute / multiply-wait / memory-wait /
// writeback and owns the carry flag.
// Ports:
//   CLK, nRESET            clock, async active-low reset
//   INSTR_VALID/IN/READY   fetch handshake and instruction word
//   INSTR                  instruction register to the ALU decoder
//   ALU_COUT, CARRY        carry-out sample and carry flag register
//   MEM_REQ/MEM_WE/MEM_ACK data memory handshake
//   REG_WE, PC_LOAD        register-file write and PC-load strobes
//   BUSY, STATE            status / debug
//
// state | meaning
// FETCH | idle, INSTR_READY high, waiting for INSTR_VALID
// EXEC  | one cycle, dispatch on op class (PC_LOAD for jmr)
// MULW  | multiply dwell, MULT_CYCLES cycles
// MEMW  | MEM_REQ held until MEM_ACK
// WB    | REG_WE for one cycle, carry update on exit
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        INSTR_VALID,
  input  logic [15:0] INSTR_IN,
  output logic        INSTR_READY,
  output logic [15:0] INSTR,
  input  logic        ALU_COUT,
  output logic        CARRY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  input  logic        MEM_ACK,
  output logic        REG_WE,
  output logic        PC_LOAD,
  output logic        BUSY,
  output logic [2:0]  STATE
);

  state_e           state_q;
  logic [15:0]      instr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] cls;
  logic       op_mem_we;
  logic       op_carry_wr;

  alu_op_classify u_classify (
    .op_i       (instr_q[15:11]),
    .bit6_i     (instr_q[6]),
    .cls_o      (cls),
    .mem_we_o   (op_mem_we),
    .carry_wr_o (op_carry_wr)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_FETCH;
      instr_q <= 16'h0000;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (INSTR_VALID) begin
            instr_q <= INSTR_IN;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_ALU: state_q <= ST_WB;
            CLS_MUL: begin
              // Counting down to zero inclusive gives MULT_CYCLES cycles in MULW.
              cnt_q   <= CNT_W'(MULT_CYCLES - 1);
              state_q <= ST_MULW;
            end
            CLS_MEM: state_q <= ST_MEMW;
            default: state_q <= ST_FETCH;
          endcase
        end
        ST_MULW: begin
          if (cnt_q == '0) state_q <= ST_WB;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_MEMW: begin
          if (MEM_ACK) begin
            // sti has nothing to write back; ldr and stk update a register.
            if (instr_q[15:11] == OP_STI) state_q <= ST_FETCH;
            else                          state_q <= ST_WB;
          end
        end
        ST_WB: begin
          if (op_carry_wr) carry_q <= ALU_COUT;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Strobes decode only from registered state, so an async reset of state_q
  // removes them immediately.
  assign INSTR_READY = (state_q == ST_FETCH);
  assign BUSY        = (state_q != ST_FETCH);
  assign MEM_REQ     = (state_q == ST_MEMW);
  assign MEM_WE      = MEM_REQ & op_mem_we;
  assign REG_WE      = (state_q == ST_WB);
  assign PC_LOAD     = (state_q == ST_EXEC) && (cls == CLS_JMP);
  assign INSTR       = instr_q;
  assign CARRY       = carry_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer (MULT_CYCLES=4).
module tb_alu_exec_sequencer;

  logic        CLK;
  logic        nRESET;
  logic        INSTR_VALID;
  logic [15:0] INSTR_IN;
  logic        INSTR_READY;
  logic [15:0] INSTR;
  logic        ALU_COUT;
  logic        CARRY;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        MEM_ACK;
  logic        REG_WE;
  logic        PC_LOAD;
  logic        BUSY;
  logic [2:0]  STATE;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_sequencer #(.MULT_CYCLES(4), .CNT_W(4)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .INSTR_VALID(INSTR_VALID), .INSTR_IN(INSTR_IN), .INSTR_READY(INSTR_READY),
    .INSTR(INSTR), .ALU_COUT(ALU_COUT), .CARRY(CARRY),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ACK(MEM_ACK),
    .REG_WE(REG_WE), .PC_LOAD(PC_LOAD), .BUSY(BUSY), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word for a single cycle; returns in the EXEC cycle.
  task automatic issue(input logic [15:0] w);
    INSTR_IN    = w;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; INSTR_VALID = 1'b0; INSTR_IN = 16'h0; ALU_COUT = 1'b0; MEM_ACK = 1'b0;
    #3;
    n_checks++; if ({STATE, INSTR_READY, BUSY, REG_WE, MEM_REQ, PC_LOAD} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL por_outputs got st=%0d rdy=%b busy=%b we=%b req=%b pcl=%b exp st=0 rdy=1 others 0", STATE, INSTR_READY, BUSY, REG_WE, MEM_REQ, PC_LOAD); end
    n_checks++; if ({INSTR, CARRY} !== {16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL por_regs got instr=%h carry=%b exp 0000/0", INSTR, CARRY); end
    #9 nRESET = 1'b1;
    tick();
    // Set CARRY so the mid-operation reset has something to clear.
    ALU_COUT = 1'b1;
    issue(16'h0812);
    tick(); tick();
    n_checks++; if (CARRY !== 1'b1) begin
      n_fail++; $display("FAIL reset_setup_carry got=%b exp=1", CARRY); end
    ALU_COUT = 1'b0;
    issue(16'h4800);
    tick(); tick();
    n_checks++; if (STATE !== 3'd2) begin
      n_fail++; $display("FAIL reset_in_mulw got=%0d exp=2", STATE); end
    #2 nRESET = 1'b0;
    #1;
    n_checks++; if ({STATE, INSTR, CARRY, INSTR_READY, REG_WE, MEM_REQ} !== {3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset got st=%0d instr=%h carry=%b rdy=%b we=%b req=%b exp 0/0000/0/1/0/0", STATE, INSTR, CARRY, INSTR_READY, REG_WE, MEM_REQ); end
    #2 nRESET = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    ALU_COUT = 1'b1;
    issue(16'h0812);
    n_checks++; if ({STATE, INSTR, BUSY, INSTR_READY, REG_WE} !== {3'd1, 16'h0812, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL alu_exec got st=%0d instr=%h busy=%b rdy=%b we=%b exp 1/0812/1/0/0", STATE, INSTR, BUSY, INSTR_READY, REG_WE); end
    tick();
    n_checks++; if ({STATE, REG_WE, CARRY} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alu_wb got st=%0d we=%b carry=%b exp 4/1/0", STATE, REG_WE, CARRY); end
    tick();
    n_checks++; if ({STATE, INSTR_READY, REG_WE, CARRY} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL alu_done got st=%0d rdy=%b we=%b carry=%b exp 0/1/0/1", STATE, INSTR_READY, REG_WE, CARRY); end
  endtask

  task automatic test_mul();
    ALU_COUT = 1'b0;
    issue(16'h4800);
    n_checks++; if (STATE !== 3'd1) begin
      n_fail++; $display("FAIL mul_exec got=%0d exp=1", STATE); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if ({STATE, REG_WE, CARRY} !== {3'd2, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL mul_wait%0d got st=%0d we=%b carry=%b exp 2/0/1", i, STATE, REG_WE, CARRY); end
    end
    tick();
    n_checks++; if ({STATE, REG_WE, CARRY} !== {3'd4, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL mul_wb got st=%0d we=%b carry=%b exp 4/1/1", STATE, REG_WE, CARRY); end
    tick();
    n_checks++; if ({STATE, CARRY} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL mul_carry got st=%0d carry=%b exp 0/0", STATE, CARRY); end
  endtask

  task automatic test_store();
    issue(16'h7800);
    n_checks++; if ({STATE, MEM_REQ} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL sti_exec got st=%0d req=%b exp 1/0", STATE, MEM_REQ); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({STATE, MEM_REQ, MEM_WE, REG_WE} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL sti_memw%0d got st=%0d req=%b we=%b rwe=%b exp 3/1/1/0", i, STATE, MEM_REQ, MEM_WE, REG_WE); end
    end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    n_checks++; if ({STATE, MEM_REQ, REG_WE} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sti_done got st=%0d req=%b rwe=%b exp 0/0/0", STATE, MEM_REQ, REG_WE); end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    n_checks++; if ({STATE, MEM_REQ, BUSY} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL stray_ack got st=%0d req=%b busy=%b exp 0/0/0", STATE, MEM_REQ, BUSY); end
  endtask

  task automatic test_push_load();
    // CARRY is 0 here; drive ALU_COUT=1 so a wrongful update would show.
    ALU_COUT = 1'b1;
    issue(16'h6840);
    MEM_ACK = 1'b1;
    tick();
    n_checks++; if ({STATE, MEM_REQ, MEM_WE} !== {3'd3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL push_memw got st=%0d req=%b we=%b exp 3/1/1", STATE, MEM_REQ, MEM_WE); end
    tick();
    MEM_ACK = 1'b0;
    n_checks++; if ({STATE, REG_WE, MEM_REQ} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL push_wb got st=%0d rwe=%b req=%b exp 4/1/0", STATE, REG_WE, MEM_REQ); end
    tick();
    n_checks++; if ({STATE, REG_WE, CARRY} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL push_carry got st=%0d rwe=%b carry=%b exp 0/0/0", STATE, REG_WE, CARRY); end
    issue(16'h7000);
    tick();
    n_checks++; if ({STATE, MEM_REQ, MEM_WE} !== {3'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ldr_memw got st=%0d req=%b we=%b exp 3/1/0", STATE, MEM_REQ, MEM_WE); end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    n_checks++; if ({STATE, REG_WE} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL ldr_wb got st=%0d rwe=%b exp 4/1", STATE, REG_WE); end
    tick();
    n_checks++; if ({STATE, CARRY} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL ldr_carry got st=%0d carry=%b exp 0/0", STATE, CARRY); end
    ALU_COUT = 1'b0;
  endtask

  task automatic test_jmp_nop();
    issue(16'hE000);
    n_checks++; if ({STATE, PC_LOAD, REG_WE} !== {3'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL jmr_exec got st=%0d pcl=%b rwe=%b exp 1/1/0", STATE, PC_LOAD, REG_WE); end
    tick();
    n_checks++; if ({STATE, PC_LOAD, REG_WE} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL jmr_done got st=%0d pcl=%b rwe=%b exp 0/0/0", STATE, PC_LOAD, REG_WE); end
    issue(16'h8000);
    n_checks++; if ({STATE, PC_LOAD, REG_WE, MEM_REQ} !== {3'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL nop_exec got st=%0d pcl=%b rwe=%b req=%b exp 1/0/0/0", STATE, PC_LOAD, REG_WE, MEM_REQ); end
    tick();
    n_checks++; if ({STATE, INSTR_READY} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL nop_done got st=%0d rdy=%b exp 0/1", STATE, INSTR_READY); end
  endtask

  task automatic test_back_to_back();
    INSTR_IN    = 16'h0812;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_IN = 16'h2000;
    n_checks++; if ({STATE, INSTR} !== {3'd1, 16'h0812}) begin
      n_fail++; $display("FAIL b2b_exec1 got st=%0d instr=%h exp 1/0812", STATE, INSTR); end
    tick();
    n_checks++; if ({STATE, INSTR} !== {3'd4, 16'h0812}) begin
      n_fail++; $display("FAIL b2b_wb1 got st=%0d instr=%h exp 4/0812", STATE, INSTR); end
    tick();
    n_checks++; if ({STATE, INSTR_READY} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL b2b_fetch got st=%0d rdy=%b exp 0/1", STATE, INSTR_READY); end
    tick();
    INSTR_VALID = 1'b0;
    n_checks++; if ({STATE, INSTR} !== {3'd1, 16'h2000}) begin
      n_fail++; $display("FAIL b2b_exec2 got st=%0d instr=%h exp 1/2000", STATE, INSTR); end
    tick();
    tick();
    n_checks++; if (STATE !== 3'd0) begin
      n_fail++; $display("FAIL b2b_done got st=%0d exp 0", STATE); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_store();
    test_push_load();
    test_jmp_nop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
